// File: rtl/enemy_bullet_pool.sv
// Pool of four enemy bullets: spawn on request, descend on a tick, collide with the player box.
// Optional BULLET_SHIELD_EN: after each hit, further overlaps are ignored for 2*STEP_DIV cycles.
module enemy_bullet_pool #(
    parameter int STEP_DIV   = 250000,
    parameter int STEP_PX    = 4,
    parameter int X0         = 64,
    parameter int DX         = 64,
    parameter int Y0         = 40,
    parameter int DY         = 40,
    parameter int SCREEN_H   = 480,
    parameter int PLAYER_Y   = 440,
    parameter int PLAYER_W   = 32,
    parameter int LIVES_INIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        fire_req,
    input  logic [5:0]  ID_enemy_tiro_X,
    input  logic [5:0]  ID_enemy_tiro_Y,
    input  logic [9:0]  player_x,
    output logic [39:0] bullet_x,
    output logic [39:0] bullet_y,
    output logic [3:0]  bullet_active,
    output logic        hit,
    output logic        fire_drop,
    output logic [1:0]  lives,
    output logic        jogador_vivo
);
    localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    act_q, act_d;
    logic [9:0]    x_q [4];
    logic [9:0]    x_d [4];
    logic [9:0]    y_q [4];
    logic [9:0]    y_d [4];
    logic          hit_q, hit_d;
    logic          drop_q, drop_d;
    logic [1:0]    lives_q, lives_d;

    logic [10:0]   ny [4];
    logic [3:0]    overlap;
    logic [3:0]    hit_mask;
    logic [3:0]    grant_oh;
    logic          wrap, alive, fire_ok, shield_on;
    logic [9:0]    spawn_x, spawn_y;
    logic          unused_id_bits;

    assign unused_id_bits = ^ID_enemy_tiro_X[5:3];

    assign wrap    = (tick_q == TW'(STEP_DIV - 1));
    assign alive   = (lives_q != 2'd0);
    assign spawn_x = 10'(X0 + 32'(ID_enemy_tiro_X[2:0]) * DX + 14);
    assign spawn_y = 10'(Y0 + 32'(ID_enemy_tiro_Y) * DY + 16);
    assign fire_ok = fire_req && alive && (act_q != 4'hF);

    // Widened to 11 bits so box edges near 1023 cannot wrap around.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            logic [10:0] bx, by, px;
            assign bx = {1'b0, x_q[gi]};
            assign by = {1'b0, y_q[gi]};
            assign px = {1'b0, player_x};
            assign ny[gi] = by + 11'(STEP_PX);
            assign overlap[gi] = act_q[gi]
                && (bx < px + 11'(PLAYER_W)) && (px < bx + 11'd4)
                && (by < 11'(PLAYER_Y + 16)) && (11'(PLAYER_Y) < by + 11'd8);
            assign bullet_x[gi*10 +: 10] = x_q[gi];
            assign bullet_y[gi*10 +: 10] = y_q[gi];
        end
    endgenerate

`ifdef BULLET_SHIELD_EN
    logic [31:0] shield_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            shield_q <= '0;
        else if (restart)
            shield_q <= '0;
        else if (|hit_mask)
            shield_q <= 32'(2 * STEP_DIV);
        else if (shield_q != '0)
            shield_q <= shield_q - 32'd1;
    end
    assign shield_on = (shield_q != '0);
`else
    assign shield_on = 1'b0;
`endif

    assign hit_mask = (alive && !shield_on) ? overlap : 4'b0;

    always_comb begin
        grant_oh = 4'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!act_q[i]) begin
                grant_oh    = 4'b0;
                grant_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        tick_d  = wrap ? '0 : tick_q + 1'b1;
        act_d   = act_q;
        x_d     = x_q;
        y_d     = y_q;
        hit_d   = |hit_mask;
        drop_d  = fire_req && !fire_ok;
        lives_d = (|hit_mask) ? lives_q - 2'd1 : lives_q;
        for (int i = 0; i < 4; i++) begin
            // A slot granted this cycle was inactive, so it never collides with a free.
            if (hit_mask[i]) begin
                act_d[i] = 1'b0;
            end else if (act_q[i] && wrap && alive) begin
                if (ny[i] >= 11'(SCREEN_H))
                    act_d[i] = 1'b0;
                else
                    y_d[i] = ny[i][9:0];
            end
            if (fire_ok && grant_oh[i]) begin
                act_d[i] = 1'b1;
                x_d[i]   = spawn_x;
                y_d[i]   = spawn_y;
            end
        end
        if (restart) begin
            tick_d  = '0;
            act_d   = '0;
            x_d     = '{default: '0};
            y_d     = '{default: '0};
            hit_d   = 1'b0;
            drop_d  = 1'b0;
            lives_d = 2'(LIVES_INIT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q  <= '0;
            act_q   <= '0;
            x_q     <= '{default: '0};
            y_q     <= '{default: '0};
            hit_q   <= 1'b0;
            drop_q  <= 1'b0;
            lives_q <= 2'(LIVES_INIT);
        end else begin
            tick_q  <= tick_d;
            act_q   <= act_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hit_q   <= hit_d;
            drop_q  <= drop_d;
            lives_q <= lives_d;
        end
    end

    assign bullet_active = act_q;
    assign hit           = hit_q;
    assign fire_drop     = drop_q;
    assign lives         = lives_q;
    assign jogador_vivo  = alive;
endmodule

// File: tb/tb_enemy_bullet_pool.sv
// Scoreboard bench for enemy_bullet_pool: a per-cycle reference model pushes expected outputs,
// a negedge monitor pops and compares; directed scenarios add explicit constant checks.
module tb_enemy_bullet_pool;
    localparam int STEP_DIV   = 4;
    localparam int STEP_PX    = 8;
    localparam int X0         = 64;
    localparam int DX         = 64;
    localparam int Y0         = 40;
    localparam int DY         = 40;
    localparam int SCREEN_H   = 480;
    localparam int PLAYER_Y   = 440;
    localparam int PLAYER_W   = 32;
    localparam int LIVES_INIT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        restart = 1'b0;
    logic        fire_req = 1'b0;
    logic [5:0]  idx = '0;
    logic [5:0]  idy = '0;
    logic [9:0]  player_x = 10'd600;
    logic [39:0] bullet_x, bullet_y;
    logic [3:0]  bullet_active;
    logic        hit, fire_drop, jogador_vivo;
    logic [1:0]  lives;

    enemy_bullet_pool #(
        .STEP_DIV(STEP_DIV), .STEP_PX(STEP_PX), .X0(X0), .DX(DX), .Y0(Y0), .DY(DY),
        .SCREEN_H(SCREEN_H), .PLAYER_Y(PLAYER_Y), .PLAYER_W(PLAYER_W), .LIVES_INIT(LIVES_INIT)
    ) dut (
        .clk(clk), .reset(reset), .restart(restart), .fire_req(fire_req),
        .ID_enemy_tiro_X(idx), .ID_enemy_tiro_Y(idy), .player_x(player_x),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
        .hit(hit), .fire_drop(fire_drop), .lives(lives), .jogador_vivo(jogador_vivo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  act;
        logic [39:0] bx;
        logic [39:0] by;
        logic        hit;
        logic        drop;
        logic [1:0]  lives;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: bullets as plain integer coordinates, advanced once per clock.
    bit m_act[4];
    int m_x[4];
    int m_y[4];
    int m_lives, m_cyc;
    bit m_hit, m_drop;

    function automatic void m_clear();
        for (int i = 0; i < 4; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
        m_lives = LIVES_INIT; m_cyc = 0; m_hit = 0; m_drop = 0;
    endfunction

    function automatic bit m_overlap(int bx, int by, int px);
        return (bx < px + PLAYER_W) && (px < bx + 4) && (by < PLAYER_Y + 16) && (PLAYER_Y < by + 8);
    endfunction

    function automatic void m_step();
        bit hm[4];
        bit any_hit = 0;
        int slot = -1;
        bit alive = (m_lives > 0);
        bit tick = ((m_cyc % STEP_DIV) == STEP_DIV - 1);
        m_cyc++;
        for (int i = 0; i < 4; i++) begin
            hm[i] = alive && m_act[i] && m_overlap(m_x[i], m_y[i], int'(player_x));
            any_hit |= hm[i];
        end
        if (fire_req && alive)
            for (int i = 0; i < 4; i++)
                if (!m_act[i] && slot < 0) slot = i;
        m_drop = fire_req && (slot < 0);
        for (int i = 0; i < 4; i++) begin
            if (hm[i]) m_act[i] = 0;
            else if (m_act[i] && tick && alive) begin
                if (m_y[i] + STEP_PX >= SCREEN_H) m_act[i] = 0;
                else m_y[i] = m_y[i] + STEP_PX;
            end
        end
        if (slot >= 0) begin
            m_act[slot] = 1;
            m_x[slot] = (X0 + (int'(idx) % 8) * DX + 14) % 1024;
            m_y[slot] = (Y0 + int'(idy) * DY + 16) % 1024;
        end
        if (any_hit) m_lives--;
        m_hit = any_hit;
    endfunction

    function automatic exp_t m_snap();
        exp_t e;
        e.act = '0; e.bx = '0; e.by = '0;
        for (int i = 0; i < 4; i++) begin
            e.act[i] = m_act[i];
            e.bx[i*10 +: 10] = 10'(m_x[i]);
            e.by[i*10 +: 10] = 10'(m_y[i]);
        end
        e.hit = m_hit; e.drop = m_drop; e.lives = 2'(m_lives);
        return e;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_clear();
            sb_q.delete();
        end else if (restart) begin
            m_clear();
        end else begin
            m_step();
        end
        sb_q.push_back(m_snap());
    end

    always @(negedge clk) begin
        exp_t e;
        logic [39:0] mask;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            mask = '0;
            for (int i = 0; i < 4; i++)
                if (e.act[i]) mask[i*10 +: 10] = 10'h3FF;
            check("sb_active", 40'(bullet_active), 40'(e.act));
            check("sb_bullet_x", bullet_x & mask, e.bx & mask);
            check("sb_bullet_y", bullet_y & mask, e.by & mask);
            check("sb_hit", 40'(hit), 40'(e.hit));
            check("sb_fire_drop", 40'(fire_drop), 40'(e.drop));
            check("sb_lives", 40'(lives), 40'(e.lives));
            check("sb_vivo", 40'(jogador_vivo), 40'(e.lives != 2'd0));
        end
    end

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic fire_once(input int x, input int y);
        fire_req = 1'b1; idx = 6'(x); idy = 6'(y);
        @(negedge clk);
        fire_req = 1'b0;
    endtask

    task automatic run_count_hits(input int n, output int hits);
        hits = 0;
        repeat (n) begin
            @(negedge clk);
            if (hit) hits++;
        end
    endtask

    initial begin
        int hits;
        repeat (3) @(negedge clk);
        check("reset_lives", 40'(lives), 40'(LIVES_INIT));
        check("reset_active", 40'(bullet_active), 40'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single shot from column 9 (low bits 1), row 1.
        fire_once(9, 1);
        check("spawn_active", 40'(bullet_active), 40'h1);
        check("spawn_x", 40'(bullet_x[9:0]), 40'd142);
        check("spawn_y", 40'(bullet_y[9:0]), 40'd96);

        // Five back-to-back requests: the fifth is dropped.
        pulse_restart();
        for (int k = 0; k < 5; k++) begin
            fire_req = 1'b1; idx = 6'(k); idy = 6'd0;
            @(negedge clk);
            check($sformatf("burst_drop_%0d", k), 40'(fire_drop), 40'(k == 4));
        end
        fire_req = 1'b0;
        check("burst_full", 40'(bullet_active), 40'hF);
        @(negedge clk);
        check("burst_drop_clear", 40'(fire_drop), 40'd0);

        // Bullet spawned at y=472 leaves the screen on the next tick without a hit.
        pulse_restart();
        fire_once(0, 36);
        check("low_spawn_y", 40'(bullet_y[9:0]), 40'd472);
        run_count_hits(6, hits);
        check("low_freed", 40'(bullet_active), 40'd0);
        check("low_no_hit", 40'(hits), 40'd0);
        check("low_lives", 40'(lives), 40'd3);

        // Two bullets in the same column strike together: one life, one pulse.
        player_x = 10'd200;
        pulse_restart();
        fire_once(2, 0);
        fire_once(2, 0);
        check("pair_active", 40'(bullet_active), 40'h3);
        run_count_hits(230, hits);
        check("pair_hits", 40'(hits), 40'd1);
        check("pair_lives", 40'(lives), 40'd2);
        check("pair_freed", 40'(bullet_active), 40'd0);

        // Two more hits exhaust the lives.
        for (int h = 0; h < 2; h++) begin
            fire_once(2, 0);
            run_count_hits(230, hits);
            check($sformatf("single_hit_%0d", h), 40'(hits), 40'd1);
        end
        check("dead_lives", 40'(lives), 40'd0);
        check("dead_vivo", 40'(jogador_vivo), 40'd0);
        fire_once(1, 0);
        check("dead_drop", 40'(fire_drop), 40'd1);
        check("dead_no_spawn", 40'(bullet_active), 40'd0);
        pulse_restart();
        check("restart_lives", 40'(lives), 40'd3);
        check("restart_vivo", 40'(jogador_vivo), 40'd1);

        // Randomized traffic, checked only by the scoreboard.
        for (int c = 0; c < 2500; c++) begin
            fire_req = ($urandom_range(0, 3) == 0);
            idx = 6'($urandom_range(0, 23));
            idy = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) player_x = 10'($urandom_range(0, 620));
            restart = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        fire_req = 1'b0; restart = 1'b0;

        // Asynchronous reset while bullets are in flight.
        player_x = 10'd600;
        pulse_restart();
        fire_once(3, 1);
        fire_once(4, 2);
        repeat (10) @(negedge clk);
        check("flight_active", 40'(bullet_active != 4'd0), 40'd1);
        #2 reset = 1'b0;
        #1;
        check("areset_active", 40'(bullet_active), 40'd0);
        check("areset_x", bullet_x, 40'd0);
        check("areset_y", bullet_y, 40'd0);
        check("areset_hit", 40'(hit), 40'd0);
        check("areset_drop", 40'(fire_drop), 40'd0);
        check("areset_lives", 40'(lives), 40'd3);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
